// File: rtl/pe_array_ctrl_if.sv
// Handshake and control bundle between the PE-array sequencer and the
// surrounding datapath (weight/activation feeders, PEs, register files, drain sink).
interface pe_array_ctrl_if #(
    parameter int Y_DIM = 15
);
    logic             start;
    logic             abort;
    logic             filt_valid;
    logic             filt_ready;
    logic             act_valid;
    logic             act_ready;
    logic [1:0]       pe_resp;
    logic [3:0]       pe_mux_ctrl;
    logic [4:0]       pe_compute_ctrl;
    logic             wt_rf_wr_en;
    logic             wt_rf_rd_en;
    logic [Y_DIM-1:0] if_rf_wr_en;
    logic [Y_DIM-1:0] if_rf_rd_en;
    logic [Y_DIM-1:0] of_rf_wr_en;
    logic [Y_DIM-1:0] of_rf_rd_en;
    logic [3:0]       out_sel;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, abort, filt_valid, act_valid, pe_resp, out_ready,
        input  filt_ready, act_ready, pe_mux_ctrl, pe_compute_ctrl,
               wt_rf_wr_en, wt_rf_rd_en, if_rf_wr_en, if_rf_rd_en,
               of_rf_wr_en, of_rf_rd_en, out_sel, out_valid, busy, done, err
    );

    modport slave (
        input  start, abort, filt_valid, act_valid, pe_resp, out_ready,
        output filt_ready, act_ready, pe_mux_ctrl, pe_compute_ctrl,
               wt_rf_wr_en, wt_rf_rd_en, if_rf_wr_en, if_rf_rd_en,
               of_rf_wr_en, of_rf_rd_en, out_sel, out_valid, busy, done, err
    );
endinterface

// File: rtl/pe_array_ctrl.sv
// Sequencer for a PE array: loads K_TAPS weight and activation beats, runs
// K_TAPS accumulate steps, writes results back, then drains Y_DIM rows.
module pe_array_ctrl #(
    parameter int Y_DIM  = 15,
    parameter int K_TAPS = 3
) (
    input  logic           clk,
    input  logic           rst,
    pe_array_ctrl_if.slave ctrl
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD_WT,
        LOAD_ACT,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] K_LAST   = 4'(K_TAPS - 1);
    localparam logic [3:0] K_WB     = 4'(K_TAPS);
    localparam logic [3:0] ROW_LAST = 4'(Y_DIM - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_k;
    logic [3:0]       w_k_next;
    logic [3:0]       r_row;
    logic [3:0]       w_row_next;
    logic             r_err;
    logic             w_err_next;

    logic [Y_DIM-1:0] w_row_hot;
    logic             w_busy;
    logic             w_done;
    logic             w_filt_ready;
    logic             w_act_ready;
    logic             w_out_valid;
    logic             w_wt_wr;
    logic             w_wt_rd;
    logic [3:0]       w_mux;
    logic [4:0]       w_comp;
    logic [3:0]       w_out_sel;
    logic [Y_DIM-1:0] w_if_wr;
    logic [Y_DIM-1:0] w_if_rd;
    logic [Y_DIM-1:0] w_of_wr;
    logic [Y_DIM-1:0] w_of_rd;

    genvar gi;
    generate
        for (gi = 0; gi < Y_DIM; gi++) begin : g_row_dec
            assign w_row_hot[gi] = (r_row == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_row   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
            r_row   <= w_row_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_row_next   = r_row;
        w_err_next   = r_err;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_filt_ready = 1'b0;
        w_act_ready  = 1'b0;
        w_out_valid  = 1'b0;
        w_wt_wr      = 1'b0;
        w_wt_rd      = 1'b0;
        w_mux        = 4'b0000;
        w_comp       = 5'b00000;
        w_out_sel    = 4'd0;
        w_if_wr      = '0;
        w_if_rd      = '0;
        w_of_wr      = '0;
        w_of_rd      = '0;

        case (r_state)
            IDLE: begin
                if (ctrl.start) begin
                    w_state_next = LOAD_WT;
                    w_err_next   = 1'b0;
                    w_k_next     = '0;
                    w_row_next   = '0;
                end
            end
            LOAD_WT: begin
                w_busy       = 1'b1;
                w_filt_ready = 1'b1;
                if (ctrl.filt_valid) begin
                    w_wt_wr = 1'b1;
                    if (r_k == K_LAST) begin
                        w_k_next     = '0;
                        w_state_next = LOAD_ACT;
                    end else begin
                        w_k_next = r_k + 4'd1;
                    end
                end
            end
            LOAD_ACT: begin
                w_busy      = 1'b1;
                w_act_ready = 1'b1;
                if (ctrl.act_valid) begin
                    w_if_wr = '1;
                    if (r_k == K_LAST) begin
                        w_k_next     = '0;
                        w_state_next = COMPUTE;
                    end else begin
                        w_k_next = r_k + 4'd1;
                    end
                end
            end
            COMPUTE: begin
                w_busy = 1'b1;
                // k reaching K_TAPS marks the single write-back cycle before draining
                if (r_k == K_WB) begin
                    w_of_wr      = '1;
                    w_k_next     = '0;
                    w_row_next   = '0;
                    w_state_next = DRAIN;
                end else if (ctrl.pe_resp[0]) begin
                    w_wt_rd  = 1'b1;
                    w_if_rd  = '1;
                    w_k_next = r_k + 4'd1;
                    if (r_k == 4'd0) begin
                        w_comp = 5'b11111;
                        w_mux  = 4'b0011;
                    end else begin
                        w_comp = 5'b10011;
                        w_mux  = 4'b0111;
                    end
                end
            end
            DRAIN: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                w_mux       = 4'b1000;
                w_out_sel   = r_row;
                w_of_rd     = w_row_hot;
                if (ctrl.out_ready) begin
                    if (r_row == ROW_LAST) begin
                        w_row_next   = '0;
                        w_state_next = DONE;
                    end else begin
                        w_row_next = r_row + 4'd1;
                    end
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (r_state != IDLE && ctrl.pe_resp[1]) begin
            w_state_next = IDLE;
            w_err_next   = 1'b1;
            w_k_next     = '0;
            w_row_next   = '0;
        end

        // abort wins over everything, including an error or a start, and leaves err as it was
        if (ctrl.abort) begin
            w_state_next = IDLE;
            w_err_next   = r_err;
            w_k_next     = '0;
            w_row_next   = '0;
        end
    end

    assign ctrl.busy            = w_busy;
    assign ctrl.done            = w_done;
    assign ctrl.err             = r_err;
    assign ctrl.filt_ready      = w_filt_ready;
    assign ctrl.act_ready       = w_act_ready;
    assign ctrl.out_valid       = w_out_valid;
    assign ctrl.wt_rf_wr_en     = w_wt_wr;
    assign ctrl.wt_rf_rd_en     = w_wt_rd;
    assign ctrl.pe_mux_ctrl     = w_mux;
    assign ctrl.pe_compute_ctrl = w_comp;
    assign ctrl.out_sel         = w_out_sel;
    assign ctrl.if_rf_wr_en     = w_if_wr;
    assign ctrl.if_rf_rd_en     = w_if_rd;
    assign ctrl.of_rf_wr_en     = w_of_wr;
    assign ctrl.of_rf_rd_en     = w_of_rd;
endmodule
